// File: rtl/button_debouncer.sv
// button_debouncer: synchronises and debounces a push-button, reporting the pressed level,
// press/release/long-press strobes and a wrapping press counter.
`timescale 1ns/1ps
module button_debouncer #(
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_CYCLES   = 1024,
    parameter bit ACTIVE_LOW    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);
    localparam int W = $clog2(LONG_CYCLES + 1);
    localparam logic [W-1:0] S = W'(STABLE_CYCLES);
    localparam logic [W-1:0] L = W'(LONG_CYCLES);
    typedef enum logic [2:0] {IDLE, DEB_PRESS, PRESSED, LONG, DEB_RELEASE} state_t;
    state_t state, origin;
    logic [1:0] sync;
    logic [W-1:0] stab, hold;
    logic sample;
    assign sample = sync[1] ^ ACTIVE_LOW;
    function automatic logic [W-1:0] inc(input logic [W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            sync          <= {2{ACTIVE_LOW}};
            state         <= IDLE;
            origin        <= PRESSED;
            stab          <= '0;
            hold          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            sync          <= {sync[0], btn_raw};
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            case (state)
                IDLE: if (sample) begin
                    if (STABLE_CYCLES == 1) begin
                        state       <= PRESSED;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold        <= '0;
                        stab        <= '0;
                    end else begin
                        state <= DEB_PRESS;
                        stab  <= W'(1);
                    end
                end
                DEB_PRESS: if (!sample) begin
                    state <= IDLE;
                    stab  <= '0;
                end else if (inc(stab) >= S) begin
                    state       <= PRESSED;
                    level       <= 1'b1;
                    press_pulse <= 1'b1;
                    press_count <= press_count + 8'd1;
                    hold        <= '0;
                    stab        <= '0;
                end else stab <= inc(stab);
                PRESSED, LONG: if (!sample) begin
                    // A single-sample threshold needs no confirmation window.
                    if (STABLE_CYCLES == 1) begin
                        state         <= IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        state  <= DEB_RELEASE;
                        origin <= state;
                        stab   <= W'(1);
                    end
                end else if (state == PRESSED) begin
                    hold <= inc(hold);
                    if (inc(hold) >= L) begin
                        state      <= LONG;
                        long_pulse <= 1'b1;
                    end
                end
                DEB_RELEASE: if (sample) begin
                    state <= origin;
                    stab  <= '0;
                end else if (inc(stab) >= S) begin
                    state         <= IDLE;
                    level         <= 1'b0;
                    release_pulse <= 1'b1;
                    stab          <= '0;
                end else stab <= inc(stab);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, number of consecutive stable samples required to accept a level change (legal range >= 1).
REQ-002 SHALL have parameter LONG_CYCLES, default 1024, number of accepted-press cycles before a long press is flagged (must be > STABLE_CYCLES).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = raw input reads 0 when pressed (board push-button).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port btn_raw  input  1  asynchronous raw pin from the board button.
REQ-007 SHALL have port level  output  1  debounced pressed state, 1 = pressed, polarity-normalised; this is what feeds the CPU's io_in bit.
REQ-008 SHALL have port press_pulse  output  1  one-cycle strobe on accepted press.
REQ-009 SHALL have port release_pulse  output  1  one-cycle strobe on accepted release.
REQ-010 SHALL have port long_pulse  output  1  one-cycle strobe when a press has been held LONG_CYCLES cycles.
REQ-011 SHALL have port press_count  output  8  number of accepted presses, modulo 256.

Function
REQ-012 SHALL pass btn_raw through a two-flop synchroniser; sample = sync output XOR ACTIVE_LOW (1 = pressed).
REQ-013 SHALL implement FSM states IDLE, DEB_PRESS, PRESSED, LONG, DEB_RELEASE.
REQ-014 IDLE: sample=1 -> DEB_PRESS with stability counter = 1; otherwise stay.
REQ-015 DEB_PRESS: sample=1 increments counter; on the edge where counter would reach STABLE_CYCLES -> PRESSED, level=1, press_pulse=1 for that one cycle, press_count+1, hold counter cleared; sample=0 -> IDLE, counter cleared, no pulse.
REQ-016 With STABLE_CYCLES=1, DEB_PRESS SHALL be bypassed: IDLE goes directly to PRESSED on the first sample=1.
REQ-017 Latency: btn_raw held pressed from rising edge 0 SHALL give level=1 and press_pulse=1 immediately after edge STABLE_CYCLES+2; release latency is identical.
REQ-018 PRESSED: hold counter increments each cycle; on reaching LONG_CYCLES -> LONG with long_pulse=1 for one cycle; long_pulse SHALL fire at most once per press.
REQ-019 PRESSED or LONG with sample=0 -> DEB_RELEASE, remembering the origin state; hold counter frozen while in DEB_RELEASE.
REQ-020 DEB_RELEASE: sample=0 for STABLE_CYCLES consecutive samples -> IDLE, level=0, release_pulse=1 for one cycle; sample=1 before then -> back to origin state (PRESSED or LONG), counter cleared, no pulses, level stays 1.
REQ-021 level SHALL remain constant through every DEB_* state (no glitch visible downstream).
REQ-022 press_count SHALL wrap 255 -> 0 without any other side effect.
REQ-023 press_pulse, release_pulse, long_pulse SHALL be registered, never asserted together, and never asserted in consecutive cycles.
REQ-024 Counters SHALL be sized $clog2(LONG_CYCLES+1) bits and saturate, never wrap.

Reset
REQ-025 While rst=1 at a clock edge: synchroniser flops load the unpressed raw value (ACTIVE_LOW), state=IDLE, counters=0, level=0, all pulses=0, press_count=0.
REQ-026 Reset mid-press SHALL abort without release_pulse; if button is still held after rst deasserts, a new press is accepted after STABLE_CYCLES+2 edges.
REQ-027 Reset asserted in the same cycle a pulse would fire SHALL take priority; the pulse is suppressed.

Verification (STABLE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
REQ-028 Clean press: btn_raw 1->0 held -> level=1 and press_pulse single cycle after edge 6; press_count=1.
REQ-029 Bounce: btn_raw low 3 cycles, high 1, low held -> no pulse from first burst; press_pulse exactly once, 6 edges after final falling edge.
REQ-030 Long press: hold 30 cycles past acceptance -> exactly one long_pulse, 20 cycles after press_pulse; then release -> one release_pulse, level=0.
REQ-031 Release glitch: while pressed, btn_raw high 2 cycles then low -> level stays 1, no release_pulse, no second press_pulse.
REQ-032 Wrap and reset: 256 clean presses -> press_count=0; rst mid-press -> all outputs 0 next cycle, no release_pulse, new press_pulse 6 edges after rst deasserts.
